flash_loader: RTL and testbench
===============================

# flash_loader

Boot-time controller that copies a contiguous image from the SPI NOR flash (READ command 0x03) into the PSRAM-backed cache. It sequences the flash SPI port bit by bit and packs bytes into little-endian 32-bit words. It then issues one cache write per word through the cache's `write_enable`/`busy` handshake. It sits between the flash pins and the cache front-end port and owns both until `done`, after which the CPU/test logic takes the cache port.

## Interface
- `STARTUP_WAIT`, default 1_000_000: `clk` cycles after reset before the first transfer may start (flash power-up).
- `FLASH_ADDR`, default 24'h000000: first flash byte address.
- `CACHE_ADDR`, default 32'h0000_0000: cache byte address of the first word. Must be 4-aligned.
- `TRANSFER_BYTES`, default 32'h0020_0000: bytes to copy. Must be a multiple of 4 and ≥ 4.
- `clk` in, 1: single clock for all logic, the cache clock domain.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: level. Sampled in IDLE and DONE; when high, a transfer begins.
- `flash_clk` out, 1: SPI clock, mode 0, `clk`/2.
- `flash_mosi` out, 1: SPI data to flash.
- `flash_cs` out, 1: SPI chip select, active low.
- `flash_miso` in, 1: SPI data from flash.
- `cache_address` out, 32: byte address of the word being written.
- `cache_data_in` out, 32: word being written.
- `cache_write_enable` out, 4: byte strobes. Either 4'b1111 or 0.
- `cache_busy` in, 1: cache busy flag.
- `busy` out, 1: high from leaving IDLE until entering DONE.
- `done` out, 1: high in DONE.

## Operation
Reset values:
- `flash_clk`=0, `flash_mosi`=0, `flash_cs`=1.
- `cache_address`=`CACHE_ADDR`, `cache_data_in`=0, `cache_write_enable`=0.
- `busy`=0, `done`=0.
- State is POWER_WAIT, counter=0.

States:
- **POWER_WAIT**: count up to `STARTUP_WAIT`-1, then go to IDLE.
- **IDLE**: if `start`=1, then: `flash_cs`←0; load shift register with {8'h03, `FLASH_ADDR`}; bit count←32; go to SEND.
- **SEND**: shift out the register MSB-first.
  - Phase 0: `flash_clk`←0, `flash_mosi`←MSB.
  - Phase 1: `flash_clk`←1.
  - After the 32nd phase 1, go to READ with byte index=0.
- **READ**: 8 SPI clocks per byte.
  - Phase 0: `flash_clk`←1.
  - Phase 1: `flash_clk`←0 and shift `flash_miso` in (MSB-first).
  - After 8 bits, place the byte in lane [8·idx+7 : 8·idx] of the word buffer. Byte 0 goes to [7:0].
  - After byte 3, load `cache_data_in` from the word buffer, set `cache_write_enable`←4'b1111, go to WRITE.
- **WRITE**: hold 1 cycle so the cache sees the request, then go to WAIT_CACHE.
- **WAIT_CACHE**: when `cache_busy`=0, set `cache_write_enable`←0 and decrement remaining bytes by 4.
  - If remaining=0: `flash_cs`←1, go to DONE.
  - Otherwise: `cache_address`←`cache_address`+4, go to READ.
  - `flash_clk` stays 0 and `flash_cs` stays 0 for the whole stall. This is legal SPI clock suspension, and the flash keeps streaming sequential bytes.
- **DONE**: `done`=1. If `start`=1, restart as in IDLE, with `cache_address`←`CACHE_ADDR` and remaining←`TRANSFER_BYTES`.

Width and boundary rules:
- The remaining-bytes counter is 32 bits.
- Address arithmetic wraps at 2^32 with no check.
- An assertion of `rst` in any state returns every output to its reset value asynchronously. `flash_cs` rises immediately, aborting the flash read, and any pending cache write is dropped with `write_enable`=0.
- `start` is ignored outside IDLE and DONE.
- `cache_busy` high during IDLE or DONE is ignored.

## Timing
- Command plus address: 64 `clk` cycles from leaving IDLE to entering READ.
- Each byte takes 16 cycles, so each word takes 64 cycles plus 1 cycle (WRITE) plus the WAIT_CACHE stall of N cycles, with N ≥ 1.
- `cache_address`, `cache_data_in` and `cache_write_enable` are stable from WRITE entry until the WAIT_CACHE exit cycle.
- `flash_mosi` changes only when `flash_clk` is low.
- `flash_miso` is sampled on the cycle in which `flash_clk` falls, one `clk` after the rising edge.
- `done` rises on the cycle after the last cache handshake, in the same cycle that `flash_cs` is 1.

## Structure
- Package `flash_loader_pkg` holds:
  - the state enum (POWER_WAIT, IDLE, SEND, READ, WRITE, WAIT_CACHE, DONE);
  - `FLASH_CMD_READ`=8'h03;
  - `SPI_ADDR_BITS`=24.
- Sub-module `flash_spi_shifter` handles one-bit-per-two-cycle serialization. It takes n-bit TX and returns 8-bit RX, with `go`/`bit_done` signals. It drives `flash_clk` and `flash_mosi` and samples `flash_miso`. The parent owns `flash_cs` and the cache port.

## Test plan
- **Startup and command:** `STARTUP_WAIT`=10, `start`=1.
  - `flash_cs` falls at cycle 10 or later.
  - The MOSI bits captured on rising edges equal 0x03000000.
  - There are exactly 32 SPI clocks before the first READ.
- **Word packing:** flash model returns 0x61,0x62,0x63,0x64 at address 0 with `cache_busy` always 0.
  - First cache write: address 0, data 0x64636261, strobes 4'b1111.
- **Cache stall:** `TRANSFER_BYTES`=8, `cache_busy` held high for 20 cycles after each write.
  - `flash_clk` stays 0 during the stall.
  - The second word is written to address 4 with flash bytes 4–7.
- **Completion:** `TRANSFER_BYTES`=8.
  - Exactly 2 writes occur.
  - `flash_cs`=1 and `done`=1 one cycle after the second handshake; `busy`=0.
- **Reset mid-transfer:** assert `rst` during byte 2 of READ.
  - In the same cycle: `flash_cs`=1, `cache_write_enable`=0, `busy`=0.
  - After reset release, the power wait restarts.
- **Restart from DONE:** pulse `start` again.
  - Writes begin again at `CACHE_ADDR`, with a new 0x03 command.

Source files
------------

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time flash-to-cache loader.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    POWER_WAIT,
    IDLE,
    SEND,
    READ,
    WRITE,
    WAIT_CACHE,
    DONE
  } state_e;

  typedef logic [3:0] strobe_t;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int SPI_ADDR_BITS = 24;
  localparam int SPI_CMD_BITS = 8 + SPI_ADDR_BITS;
  localparam strobe_t STROBE_ALL = 4'b1111;

  function automatic logic [31:0] place_byte(
    input logic [31:0] w,
    input logic [1:0]  idx,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/flash_loader_if.sv
// Cache front-end write port driven by the loader until boot completes.
interface flash_loader_if;
  import flash_loader_pkg::*;

  logic [31:0] cache_address;
  logic [31:0] cache_data_in;
  strobe_t     cache_write_enable;
  logic        cache_busy;

  modport master (
    output cache_address,
    output cache_data_in,
    output cache_write_enable,
    input  cache_busy
  );

  modport slave (
    input  cache_address,
    input  cache_data_in,
    input  cache_write_enable,
    output cache_busy
  );

endinterface

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 bit engine: one bit per two clk cycles, TX MSB-first, RX MSB-first.
module flash_spi_shifter
  import flash_loader_pkg::*;
#(
  parameter int N = SPI_CMD_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] tx_i,
  input  logic         go_i,
  input  logic         tx_mode_i,
  output logic         bit_done_o,
  output logic [7:0]   rx_o,
  output logic         flash_clk_o,
  output logic         flash_mosi_o,
  input  logic         flash_miso_i
);

  logic [N-1:0] sh_q, sh_d;
  logic [7:0]   rx_q, rx_d;
  logic         ph_q, ph_d;
  logic         sclk_q, sclk_d;
  logic         mosi_q, mosi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      rx_q   <= '0;
      ph_q   <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      ph_q   <= ph_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end

  always_comb begin
    sh_d   = sh_q;
    rx_d   = rx_q;
    ph_d   = ph_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    if (load_i) begin
      sh_d = tx_i;
      ph_d = 1'b0;
    end else if (go_i) begin
      ph_d = ~ph_q;
      if (tx_mode_i) begin
        if (!ph_q) begin
          sclk_d = 1'b0;
          mosi_d = sh_q[N-1];
          sh_d   = sh_q << 1;
        end else begin
          sclk_d = 1'b1;
        end
      end else begin
        // Receive: rise, then sample on the cycle the clock falls.
        if (!ph_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          rx_d   = {rx_q[6:0], flash_miso_i};
        end
      end
    end
  end

  assign bit_done_o   = go_i & ph_q;
  assign rx_o         = {rx_q[6:0], flash_miso_i};
  assign flash_clk_o  = sclk_q;
  assign flash_mosi_o = mosi_q;

endmodule

// File: rtl/flash_loader.sv
// Copies a flash image (READ 0x03) into the cache as little-endian words.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned STARTUP_WAIT = 1_000_000,
  parameter logic [SPI_ADDR_BITS-1:0] FLASH_ADDR = 24'h000000,
  parameter logic [31:0] CACHE_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRANSFER_BYTES = 32'h0020_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           flash_clk,
  output logic           flash_mosi,
  output logic           flash_cs,
  input  logic           flash_miso,
  flash_loader_if.master cache,
  output logic           busy,
  output logic           done
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  bits_q, bits_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rem_q, rem_d;
  logic        cs_q, cs_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  strobe_t     we_q, we_d;

  logic        load, go, tx_mode, bit_done;
  logic [7:0]  rx;

  flash_spi_shifter #(
    .N (SPI_CMD_BITS)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .tx_i         ({FLASH_CMD_READ, FLASH_ADDR}),
    .go_i         (go),
    .tx_mode_i    (tx_mode),
    .bit_done_o   (bit_done),
    .rx_o         (rx),
    .flash_clk_o  (flash_clk),
    .flash_mosi_o (flash_mosi),
    .flash_miso_i (flash_miso)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= POWER_WAIT;
      cnt_q   <= '0;
      bits_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      rem_q   <= TRANSFER_BYTES;
      cs_q    <= 1'b1;
      addr_q  <= CACHE_ADDR;
      data_q  <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    idx_d   = idx_q;
    word_d  = word_q;
    rem_d   = rem_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    load    = 1'b0;
    go      = 1'b0;
    tx_mode = 1'b0;
    unique case (state_q)
      POWER_WAIT: begin
        if (cnt_q == 32'(STARTUP_WAIT - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 32'd1;
      end
      IDLE, DONE: begin
        if (start) begin
          cs_d    = 1'b0;
          load    = 1'b1;
          bits_d  = 6'(SPI_CMD_BITS);
          rem_d   = TRANSFER_BYTES;
          addr_d  = CACHE_ADDR;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        go      = 1'b1;
        tx_mode = 1'b1;
        if (bit_done) begin
          bits_d = bits_q - 6'd1;
          if (bits_q == 6'd1) begin
            bits_d  = 6'd8;
            idx_d   = '0;
            state_d = READ;
          end
        end
      end
      READ: begin
        go = 1'b1;
        if (bit_done) begin
          bits_d = bits_q - 6'd1;
          if (bits_q == 6'd1) begin
            bits_d = 6'd8;
            word_d = place_byte(word_q, idx_q, rx);
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              data_d  = place_byte(word_q, idx_q, rx);
              we_d    = STROBE_ALL;
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: state_d = WAIT_CACHE;
      WAIT_CACHE: begin
        // SPI clock is parked low here; the flash simply pauses its stream.
        if (!cache.cache_busy) begin
          we_d  = '0;
          rem_d = rem_q - 32'd4;
          if (rem_q == 32'd4) begin
            cs_d    = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 32'd4;
            state_d = READ;
          end
        end
      end
      default: state_d = POWER_WAIT;
    endcase
  end

  assign flash_cs                 = cs_q;
  assign cache.cache_address      = addr_q;
  assign cache.cache_data_in      = data_q;
  assign cache.cache_write_enable = we_q;
  assign busy = (state_q == SEND) || (state_q == READ)
             || (state_q == WRITE) || (state_q == WAIT_CACHE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader with a behavioural SPI NOR flash model.
module tb_flash_loader;

  logic clk;
  logic rst;
  logic start;
  logic flash_clk;
  logic flash_mosi;
  logic flash_cs;
  logic flash_miso;
  logic busy;
  logic done;

  flash_loader_if cif();

  flash_loader #(
    .STARTUP_WAIT   (10),
    .FLASH_ADDR     (24'h000000),
    .CACHE_ADDR     (32'h0000_0000),
    .TRANSFER_BYTES (32'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flash_clk  (flash_clk),
    .flash_mosi (flash_mosi),
    .flash_cs   (flash_cs),
    .flash_miso (flash_miso),
    .cache      (cif.master),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash model: bytes 0x61+i; first data bit valid once 32 clocks are in,
  // each later falling SPI edge advances one bit.
  logic [7:0]  fmem [0:31];
  logic [31:0] cmd_sr;
  int          rise_cnt;
  logic [7:0]  bitptr;
  logic        fclk_prev;
  logic        we_prev;
  int          wr_cnt;
  logic [7:0]  cur_byte;

  initial begin
    for (int i = 0; i < 32; i++) fmem[i] = 8'h61 + 8'(i);
  end

  assign cur_byte   = fmem[bitptr[7:3]];
  assign flash_miso = cur_byte[3'd7 - bitptr[2:0]];

  initial begin
    cmd_sr    = '0;
    rise_cnt  = 0;
    bitptr    = '0;
    fclk_prev = 1'b0;
    we_prev   = 1'b0;
    wr_cnt    = 0;
  end

  always @(negedge clk) begin
    if (flash_cs) begin
      rise_cnt <= 0;
      bitptr   <= '0;
      cmd_sr   <= '0;
    end else begin
      if (flash_clk && !fclk_prev) begin
        if (rise_cnt < 32) cmd_sr <= {cmd_sr[30:0], flash_mosi};
        rise_cnt <= rise_cnt + 1;
      end
      if (!flash_clk && fclk_prev && rise_cnt >= 32)
        bitptr <= bitptr + 8'd1;
    end
    fclk_prev <= flash_clk;
    we_prev   <= (cif.cache_write_enable == 4'hF);
    if (cif.cache_write_enable == 4'hF && !we_prev)
      wr_cnt <= wr_cnt + 1;
  end

  int checks;
  int errors;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int n;
  int base;
  int bad;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    cif.cache_busy = 1'b0;
    #2 rst = 1'b1;
    step();
    step();

    chk("rst_cs",   32'(flash_cs), 32'd1);
    chk("rst_sclk", 32'(flash_clk), 32'd0);
    chk("rst_mosi", 32'(flash_mosi), 32'd0);
    chk("rst_addr", cif.cache_address, 32'h0);
    chk("rst_data", cif.cache_data_in, 32'h0);
    chk("rst_we",   32'(cif.cache_write_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Startup: 10 power-wait cycles plus one IDLE cycle.
    start = 1'b1;
    rst   = 1'b0;
    n = 0;
    do begin step(); n++; end while (flash_cs && n < 100);
    chk("cs_fall_cycle", 32'(n), 32'd11);
    chk("busy_send", 32'(busy), 32'd1);
    start = 1'b0;
    base  = wr_cnt;

    for (int i = 0; i < 63; i++) step();
    chk("spi_clk_31", 32'(rise_cnt), 32'd31);
    step();
    chk("spi_clk_32", 32'(rise_cnt), 32'd32);
    chk("cmd_word", cmd_sr, 32'h0300_0000);

    // First word: 64 cycles of READ, then the request appears.
    n = 0;
    do begin step(); n++; end
    while (cif.cache_write_enable != 4'hF && n < 200);
    chk("word0_lat", 32'(n), 32'd64);
    chk("w0_addr", cif.cache_address, 32'h0);
    chk("w0_data", cif.cache_data_in, 32'h6463_6261);
    chk("w0_we", 32'(cif.cache_write_enable), 32'hF);
    step();
    chk("w0_hold", 32'(cif.cache_write_enable), 32'hF);
    step();
    chk("w0_release", 32'(cif.cache_write_enable), 32'h0);
    chk("addr_inc", cif.cache_address, 32'h4);

    // Second word with a 20-cycle cache stall.
    n = 0;
    do begin step(); n++; end
    while (cif.cache_write_enable != 4'hF && n < 200);
    chk("word1_lat", 32'(n), 32'd64);
    cif.cache_busy = 1'b1;
    chk("w1_addr", cif.cache_address, 32'h4);
    chk("w1_data", cif.cache_data_in, 32'h6867_6665);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (flash_clk !== 1'b0) bad++;
      if (cif.cache_write_enable !== 4'hF) bad++;
      if (flash_cs !== 1'b0) bad++;
    end
    chk("stall_bad", 32'(bad), 32'd0);
    cif.cache_busy = 1'b0;
    step();
    chk("done_hi", 32'(done), 32'd1);
    chk("done_cs", 32'(flash_cs), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_we", 32'(cif.cache_write_enable), 32'h0);
    chk("wr_count", 32'(wr_cnt - base), 32'd2);

    // cache_busy is ignored while sitting in DONE.
    cif.cache_busy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("done_stay", 32'(done), 32'd1);
    chk("wr_count2", 32'(wr_cnt - base), 32'd2);
    cif.cache_busy = 1'b0;

    // Restart from DONE.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_cs", 32'(flash_cs), 32'd0);
    chk("rs_addr", cif.cache_address, 32'h0);
    chk("rs_done", 32'(done), 32'd0);
    for (int i = 0; i < 64; i++) step();
    chk("rs_cmd", cmd_sr, 32'h0300_0000);
    n = 0;
    do begin step(); n++; end
    while (cif.cache_write_enable != 4'hF && n < 200);
    chk("rs_w0_addr", cif.cache_address, 32'h0);
    chk("rs_w0_data", cif.cache_data_in, 32'h6463_6261);

    // Reset in byte 2 of the second word's READ.
    for (int i = 0; i < 42; i++) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_cs", 32'(flash_cs), 32'd1);
    chk("ar_we", 32'(cif.cache_write_enable), 32'h0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_sclk", 32'(flash_clk), 32'd0);
    chk("ar_addr", cif.cache_address, 32'h0);
    step();
    step();
    start = 1'b1;
    rst   = 1'b0;
    n = 0;
    do begin step(); n++; end while (flash_cs && n < 100);
    chk("pw_restart", 32'(n), 32'd11);
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
